// File: rtl/lfsr_traffic_sched_pkg.sv
// Shared types and constants for the ring NoC traffic generators.
package noc_tg_pkg;

  typedef enum logic [1:0] {IDLE, DECIDE, SEND, DONE} state_t;

  localparam int unsigned LFSR_W = 8;
  // Feedback taps at bits 7,5,4,3; the XNOR form makes all-ones the lockup state.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // Default flit layout {src, dest, seq}, MSB to LSB.
  localparam int unsigned FLIT_ADDR_W   = 3;
  localparam int unsigned FLIT_SEQ_W    = 8;
  localparam int unsigned FLIT_SEQ_LSB  = 0;
  localparam int unsigned FLIT_DEST_LSB = FLIT_SEQ_W;
  localparam int unsigned FLIT_SRC_LSB  = FLIT_SEQ_W + FLIT_ADDR_W;
  localparam int unsigned FLIT_W        = 2 * FLIT_ADDR_W + FLIT_SEQ_W;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(^(v & LFSR_TAPS))};
  endfunction

endpackage

// File: rtl/lfsr8_en.sv
// 8-bit XNOR LFSR that advances only when enabled; resets to SEED.
module lfsr8_en
  import noc_tg_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/lfsr_traffic_sched.sv
// Per-node traffic injector: LFSR-driven inject decision and destination,
// valid/ready flit output, and a per-run packet counter with optional limit.
module lfsr_traffic_sched
  import noc_tg_pkg::*;
#(
  parameter int unsigned NUM_NODES = 8,
  parameter int unsigned NODE_ID   = 0,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned SEQ_W     = 8,
  parameter logic [7:0]  SEED      = 8'h01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [7:0]                rate,
  input  logic [7:0]                pkt_limit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*ADDR_W+SEQ_W-1:0] out_flit,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                pkt_cnt
);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_en;
  logic [SEQ_W-1:0]  seq;
  logic              stop_pend;
  logic [ADDR_W-1:0] dest_raw;
  logic [ADDR_W-1:0] dest;
  logic [7:0]        cnt_next;

  assign lfsr_en = (state == DECIDE);
  assign busy    = (state == DECIDE) || (state == SEND);

  lfsr8_en #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .lfsr (lfsr)
  );

  // Destination comes from the pre-advance LFSR value; our own node is skipped.
  always_comb begin
    dest_raw = ADDR_W'(32'(lfsr[ADDR_W-1:0]) % NUM_NODES);
    dest     = dest_raw;
    if (32'(dest_raw) == NODE_ID) begin
      dest = ADDR_W'((32'(dest_raw) + 32'd1) % NUM_NODES);
    end
    cnt_next = (pkt_cnt == 8'hFF) ? 8'hFF : pkt_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      done      <= 1'b0;
      pkt_cnt   <= '0;
      seq       <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pkt_cnt   <= '0;
          seq       <= '0;
          done      <= 1'b0;
          stop_pend <= 1'b0;
          if (start) state <= DECIDE;
        end
        DECIDE: begin
          if (stop) begin
            state <= IDLE;
          end else if (lfsr < rate) begin
            out_flit  <= {ADDR_W'(NODE_ID), dest, seq};
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pkt_cnt   <= cnt_next;
            seq       <= seq + 1'b1;
            stop_pend <= 1'b0;
            if (stop_pend || stop) begin
              state <= IDLE;
            end else if ((pkt_limit != 8'd0) && (cnt_next == pkt_limit)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DECIDE;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            done    <= 1'b0;
            pkt_cnt <= '0;
            seq     <= '0;
            state   <= DECIDE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_traffic_sched.sv
// Randomized and directed bench for lfsr_traffic_sched against a behavioural model.
module tb_lfsr_traffic_sched;

  localparam int AW = 3;
  localparam int SW = 8;
  localparam int FW = 2 * AW + SW;

  logic          clk = 1'b0;
  logic          rst, start, stop, out_ready;
  logic [7:0]    rate, pkt_limit;
  logic          v0, v1, busy0, busy1, done0, done1;
  logic [FW-1:0] f0, f1;
  logic [7:0]    c0, c1;

  int tests = 0;
  int fails = 0;

  logic [FW-1:0] acc0[$];
  logic [FW-1:0] acc1[$];

  always #5 clk = ~clk;

  lfsr_traffic_sched #(.NUM_NODES(8), .NODE_ID(0), .ADDR_W(AW), .SEQ_W(SW), .SEED(8'h01)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rate(rate), .pkt_limit(pkt_limit),
    .out_valid(v0), .out_ready(out_ready), .out_flit(f0), .busy(busy0), .done(done0), .pkt_cnt(c0)
  );

  lfsr_traffic_sched #(.NUM_NODES(6), .NODE_ID(1), .ADDR_W(AW), .SEQ_W(SW), .SEED(8'h01)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rate(rate), .pkt_limit(pkt_limit),
    .out_valid(v1), .out_ready(out_ready), .out_flit(f1), .busy(busy1), .done(done1), .pkt_cnt(c1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a run is active or not; while active a flit is either pending or not.
  int unsigned m_nodes[2] = '{8, 6};
  int unsigned m_id[2]    = '{0, 1};
  bit          m_run[2], m_valid[2], m_done[2], m_pend[2];
  int unsigned m_cnt[2], m_seq[2], m_lfsr[2], m_flit[2];

  function automatic int unsigned lfsr_adv(input int unsigned v);
    int unsigned fb;
    fb = ($countones(v & 32'hB8) % 2 == 0) ? 1 : 0;
    return ((v * 2) % 256) + fb;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_pend[i] = 0;
      m_cnt[i] = 0; m_seq[i] = 0; m_lfsr[i] = 1; m_flit[i] = 0;
    end
  endtask

  task automatic model_step();
    int unsigned old, d;
    for (int i = 0; i < 2; i++) begin
      if (!m_run[i]) begin
        if (!m_done[i]) begin
          m_cnt[i] = 0; m_seq[i] = 0; m_pend[i] = 0;
        end
        if (start) begin
          m_run[i] = 1;
          if (m_done[i]) begin
            m_done[i] = 0; m_cnt[i] = 0; m_seq[i] = 0;
          end
        end
      end else if (!m_valid[i]) begin
        old = m_lfsr[i];
        m_lfsr[i] = lfsr_adv(old);
        if (stop) begin
          m_run[i] = 0;
        end else if (old < rate) begin
          d = (old % (1 << AW)) % m_nodes[i];
          if (d == m_id[i]) d = (d + 1) % m_nodes[i];
          m_flit[i] = (m_id[i] << (AW + SW)) + (d << SW) + m_seq[i];
          m_valid[i] = 1;
        end
      end else begin
        if (out_ready) begin
          m_valid[i] = 0;
          m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
          m_seq[i] = (m_seq[i] + 1) % (1 << SW);
          if (m_pend[i] || stop) begin
            m_run[i] = 0;
          end else if (pkt_limit != 0 && m_cnt[i] == pkt_limit) begin
            m_run[i] = 0;
            m_done[i] = 1;
          end
          m_pend[i] = 0;
        end else if (stop) begin
          m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic cmp_one(input int i, input logic v, input logic b, input logic d,
                         input logic [7:0] c, input logic [FW-1:0] f);
    check($sformatf("valid%0d", i), 32'(v), 32'(m_valid[i]));
    check($sformatf("busy%0d", i), 32'(b), 32'(m_run[i]));
    check($sformatf("done%0d", i), 32'(d), 32'(m_done[i]));
    check($sformatf("pkt_cnt%0d", i), 32'(c), m_cnt[i]);
    if (m_valid[i]) check($sformatf("flit%0d", i), 32'(f), m_flit[i]);
  endtask

  task automatic cycle();
    if (!rst && out_ready) begin
      if (v0) acc0.push_back(f0);
      if (v1) acc1.push_back(f1);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    cmp_one(0, v0, busy0, done0, c0, f0);
    cmp_one(1, v1, busy1, done1, c1, f1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'({v0, v1}), 32'd0);
    check({tag, "_flit"}, 32'({f0, f1}), 32'd0);
    check({tag, "_busy"}, 32'({busy0, busy1}), 32'd0);
    check({tag, "_done"}, 32'({done0, done1}), 32'd0);
    check({tag, "_cnt"}, 32'({c0, c1}), 32'd0);
  endtask

  task automatic hold_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc0.delete();
    acc1.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    rate = 8'd0; pkt_limit = 8'd0;
    @(negedge clk);
    hold_reset("reset");

    // Reset while a flit is pending.
    rate = 8'd255; pkt_limit = 8'd3; out_ready = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("latency_valid", 32'(v0), 32'd1);
    cycle();
    #2;
    hold_reset("midsend_rst");

    // Ordered sequence, limit 3, ready held high.
    out_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (10) cycle();
    check("seq_count", acc0.size(), 32'd3);
    if (acc0.size() == 3) begin
      check("seq_flit0", 32'(acc0[0]), 32'h0100);
      check("seq_flit1", 32'(acc0[1]), 32'h0301);
      check("seq_flit2", 32'(acc0[2]), 32'h0702);
    end
    check("seq_done", 32'(done0), 32'd1);
    check("seq_cnt", 32'(c0), 32'd3);
    check("seq_busy", 32'(busy0), 32'd0);
    check("selfavoid_count", 32'(acc1.size() > 0), 32'd1);
    if (acc1.size() > 0) check("selfavoid_flit", 32'(acc1[0]), 32'h0A00);

    // Backpressure on the first flit.
    hold_reset("bp_rst");
    out_ready = 1'b0; pkt_limit = 8'd0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(v0), 32'd1);
      check("bp_flit", 32'(f0), 32'h0100);
      cycle();
    end
    out_ready = 1'b1; cycle();
    check("bp_cnt", 32'(c0), 32'd1);
    out_ready = 1'b0;

    // Stop during SEND without handshake: valid held, then to IDLE on acceptance.
    cycle();
    check("stop_send_valid", 32'(v0), 32'd1);
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (3) cycle();
    check("stop_hold_valid", 32'(v0), 32'd1);
    out_ready = 1'b1; cycle();
    check("stop_busy", 32'(busy0), 32'd0);
    check("stop_done", 32'(done0), 32'd0);
    cycle();

    // rate=0: no flits until stop; LFSR keeps advancing, seen by the next run.
    rate = 8'd0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) begin
      cycle();
      check("rate0_valid", 32'(v0), 32'd0);
    end
    stop = 1'b1; cycle(); stop = 1'b0;
    cycle();
    check("rate0_busy", 32'(busy0), 32'd0);
    rate = 8'd255; pkt_limit = 8'd2;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();

    // Unlimited mode: sequence wraps and the counter saturates.
    hold_reset("unl_rst");
    pkt_limit = 8'd0; rate = 8'd255; out_ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (600) cycle();
    check("unl_cnt", 32'(c0), 32'd255);
    check("unl_done", 32'(done0), 32'd0);
    check("unl_wrap", 32'(acc0.size() > 257), 32'd1);
    if (acc0.size() > 257) check("unl_seq_wrap", 32'(acc0[256][SW-1:0]), 32'd0);
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (2) cycle();
    check("unl_stop_busy", 32'(busy0), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 31) == 0) rate = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) pkt_limit = 8'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 40) == 0);
      cycle();
    end
    start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_traffic_sched.md
Name: lfsr_traffic_sched

Overview:
- Per-node traffic-injection controller for the ring NoC.
- Owns an 8-bit LFSR and sequences it so that each packet carries a pseudo-random injection decision and destination.
- Presents flits to the local router port with a valid/ready handshake and counts packets up to a programmable limit.
- Reproducible from SEED: the LFSR advances only on defined events.

Parameters:
- NUM_NODES, 8: ring size; destinations are 0..NUM_NODES-1.
- NODE_ID, 0: this node's address; used as the source field and never used as a destination.
- ADDR_W, 3: address field width; ADDR_W >= clog2(NUM_NODES).
- SEQ_W, 8: sequence-number field width.
- SEED, 8'h01: LFSR reset value; 8'hFF is illegal because it is the XNOR lockup state.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse that begins a run
- stop  in  1  one-cycle pulse that aborts a run
- rate  in  8  injection threshold; each decision cycle injects when lfsr < rate
- pkt_limit  in  8  packets per run; 0 means unlimited
- out_valid  out  1  flit valid toward the router
- out_ready  in  1  router accepts the flit
- out_flit  out  2*ADDR_W+SEQ_W  {src, dest, seq}, MSB to LSB
- busy  out  1  a run is in progress (state is DECIDE or SEND)
- done  out  1  pkt_limit reached; held until the next start
- pkt_cnt  out  8  packets accepted in the current run

Behaviour:
- Reset (asynchronous): state=IDLE, lfsr=SEED, out_valid=0, out_flit=0, busy=0, done=0, pkt_cnt=0, seq=0, stop_pend=0.
- LFSR: next = {lfsr[6:0], ~(lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3])}. It advances only on DECIDE cycles and holds in all other states.
- IDLE:
  - start -> DECIDE next cycle.
  - Clear pkt_cnt, seq and done.
  - Do not reseed the LFSR, so successive runs continue the sequence.
- DECIDE, evaluated each cycle:
  - If stop: go to IDLE.
  - Else if lfsr < rate (unsigned 8-bit):
    - d = lfsr[ADDR_W-1:0] mod NUM_NODES.
    - If d == NODE_ID, d = (d+1) mod NUM_NODES.
    - Register out_flit = {NODE_ID, d, seq}, set out_valid=1, go to SEND.
  - Else stay in DECIDE.
  - Use the pre-advance lfsr value for both the compare and the destination.
- SEND:
  - out_valid and out_flit stay stable until out_ready is sampled high.
  - On handshake: out_valid=0; pkt_cnt+1; seq+1, wrapping mod 2^SEQ_W.
  - After handshake, go to:
    - IDLE if stop_pend or stop was seen this cycle;
    - else DONE if pkt_limit != 0 and the new pkt_cnt == pkt_limit;
    - else DECIDE.
  - A stop without handshake sets stop_pend; valid is never dropped before acceptance.
- DONE: done=1. start -> clear done, pkt_cnt and seq; go to DECIDE.
- start while busy: ignored.
- stop in IDLE or DONE: ignored. stop does not assert done.
- pkt_cnt saturates at 255 when pkt_limit=0.
- rate=0: never injects and stays in DECIDE until stop.
- rate=255: injects on every decision cycle (lfsr never reaches 8'hFF).
- Minimum latency: start at cycle N -> out_valid at cycle N+2. Back-to-back packets with ready held high: one flit every 2 cycles.
- busy = (state==DECIDE || state==SEND).

Decomposition:
- Shared package noc_tg_pkg:
  - state enum {IDLE, DECIDE, SEND, DONE};
  - flit field offset/width localparams;
  - LFSR_W=8 and the tap constant.
- Sub-module lfsr8_en:
  - 8-bit XNOR LFSR with enable and seed parameter;
  - asynchronous active-high reset to SEED;
  - reusable by other traffic generators on the ring.

Test Plan:
- Reset mid-SEND (rst asserted while out_valid=1) -> all outputs zero immediately; lfsr=8'h01; next start reproduces the first flit 0x0100.
- Ordered sequence: SEED=01, NODE_ID=0, rate=255, pkt_limit=3, ready=1 -> flits 0x0100, 0x0301, 0x0702 accepted; then done=1, pkt_cnt=3, busy=0.
- Backpressure: ready=0 for 5 cycles after the first valid -> out_flit holds 0x0100 and out_valid stays 1; accepted on the first ready cycle; pkt_cnt increments once.
- Self-avoidance: NODE_ID=1, SEED=01, rate=255 -> first dest=2 (flit src=1, dest=2, seq=0, i.e. 0x0A00).
- Stop handling: stop during SEND with ready=0 -> valid held; after the ready handshake go to IDLE with done=0. rate=0 plus stop -> no flit emitted and lfsr advances once per DECIDE cycle.
- Unlimited mode: pkt_limit=0, ready=1 for 600 cycles -> seq wraps 255->0 and pkt_cnt saturates at 255; done never asserts.
